// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr
// Registered N-to-1 data multiplexer with per-channel valid/ready inputs and
// a single-entry valid/ready output slice. The channel is chosen either by an
// external index (manual mode) or by a fair round-robin pointer.
//
// Parameters:
//   WIDTH  - data bits per channel
//   N_IN   - number of input channels (2..16)
//   SEL_W  - width of sel / out_ch, $clog2(N_IN)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = manual (use sel), 1 = round-robin
//   sel        channel index used in manual mode
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   saida      registered output data
//   out_valid  saida holds an unconsumed word
//   out_ready  consumer accepts saida
//   out_ch     channel that supplied saida
//   cnt_clr    (MUX_CNT_EN only) synchronous clear of all grant counters
//   grant_cnt  (MUX_CNT_EN only) saturating 16-bit per-channel transfer
//              counters, channel i at [i*16 +: 16]
//
// Optional feature: define MUX_CNT_EN to add the per-channel grant counters.
// ---------------------------------------------------------------------------
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    output logic [N_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]        saida,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
`ifdef MUX_CNT_EN
    ,
    input  logic                    cnt_clr,
    output logic [N_IN*16-1:0]      grant_cnt
`endif
);

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [SEL_W:0]   rr_idx;
    logic [N_IN-1:0]  ready_c;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;

    // Grant selection. In round-robin mode the search starts at ptr and wraps
    // around; the index is kept one bit wider so ptr+k can be folded back
    // into range with a single subtraction (ptr < N_IN, k < N_IN).
    always_comb begin
        load_en   = !out_valid_q || out_ready;
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = '0;
        if (mode) begin
            for (int k = 0; k < N_IN; k++) begin
                rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (rr_idx >= (SEL_W+1)'(N_IN)) begin
                    rr_idx = rr_idx - (SEL_W+1)'(N_IN);
                end
                if (!grant_vld && in_valid[rr_idx[SEL_W-1:0]]) begin
                    grant     = rr_idx[SEL_W-1:0];
                    grant_vld = 1'b1;
                end
            end
        end else if ({1'b0, sel} < (SEL_W+1)'(N_IN)) begin
            grant     = sel;
            grant_vld = 1'b1;
        end
    end

    // Ready goes only to the granted channel and only when the slice can
    // take a word; a manual grant to an idle channel still shows ready.
    always_comb begin
        ready_c    = '0;
        grant_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant == SEL_W'(i)) begin
                ready_c[i] = load_en && grant_vld;
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
        xfer = |(ready_c & in_valid);
    end

    assign in_ready = ready_c;

    // Output slice and round-robin pointer next state. A load takes priority
    // over a drain so a word can be replaced in the cycle it is consumed.
    always_comb begin
        saida_d     = saida_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            saida_d     = grant_data;
            out_valid_d = 1'b1;
            out_ch_d    = grant;
            if (mode) begin
                ptr_d = (grant == SEL_W'(N_IN-1)) ? '0 : grant + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            saida_q     <= saida_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign saida     = saida_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

`ifdef MUX_CNT_EN
    logic [15:0] cnt_q [N_IN];
    logic [15:0] cnt_d [N_IN];

    // Per-channel transfer counters; clear beats a simultaneous increment
    // and each field sticks at all-ones.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (xfer && (grant == SEL_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_IN; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_rr
// Directed testbench for mux_nx1_rr with WIDTH=8, N_IN=4. Each scenario task
// drives its own vectors and compares against hand-computed values.
// Inputs change at #1 after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_mux_nx1_rr;

    localparam int WIDTH = 8;
    localparam int N_IN  = 4;

    logic            clk;
    logic            rst_n;
    logic            mode;
    logic [1:0]      sel;
    logic [31:0]     in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [7:0]      saida;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_ch;
`ifdef MUX_CNT_EN
    logic            cnt_clr;
    logic [63:0]     grant_cnt;
`endif

    int checks;
    int errors;

    mux_nx1_rr #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .saida     (saida),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 32'h0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
`ifdef MUX_CNT_EN
        cnt_clr   = 1'b0;
`endif
        #3;
        checks++;
        if (saida !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_saida: got %h expected %h", saida, 8'h00);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0);
        end
        checks++;
        if (out_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_out_ch: got %0d expected %0d", out_ch, 0);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_manual();
        mode      = 1'b0;
        sel       = 2'd2;
        in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL manual_in_ready: got %b expected %b", in_ready, 4'b0100);
        end
        tick();
        checks++;
        if (saida !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL manual_saida: got %h expected %h", saida, 8'hA5);
        end
        checks++;
        if (out_ch !== 2'd2) begin
            errors++;
            $display("[TB] FAIL manual_out_ch: got %0d expected %0d", out_ch, 2);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL manual_out_valid: got %b expected %b", out_valid, 1'b1);
        end
        // channel 3 selected but idle: ready still points at it, nothing loads
        sel      = 2'd3;
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL manual_idle_in_ready: got %b expected %b", in_ready, 4'b1000);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL manual_idle_out_valid: got %b expected %b", out_valid, 1'b0);
        end
        checks++;
        if (in_valid & in_ready) begin
            errors++;
            $display("[TB] FAIL manual_idle_transfer: got %b expected %b", in_valid & in_ready, 4'b0000);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [6];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mode      = 1'b1;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (out_ch !== exp_ch[k] || saida !== (8'h10 + 8'(exp_ch[k])) || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_seq%0d: got ch=%0d data=%h v=%b expected ch=%0d data=%h v=1",
                         k, out_ch, saida, out_valid, exp_ch[k], 8'h10 + 8'(exp_ch[k]));
            end
        end
        in_valid = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_drain: got %b expected %b", out_valid, 1'b0);
        end
    endtask

    task automatic test_wrap_skip();
        // pointer is 2 here; loading channel 2 moves it to 3
        in_valid = 4'b0100;
        tick();
        checks++;
        if (out_ch !== 2'd2) begin
            errors++;
            $display("[TB] FAIL wrap_setup_ch: got %0d expected %0d", out_ch, 2);
        end
        in_valid = 4'b0010;
        tick();
        checks++;
        if (out_ch !== 2'd1 || saida !== 8'h11) begin
            errors++;
            $display("[TB] FAIL wrap_skip_ch1: got ch=%0d data=%h expected ch=1 data=11", out_ch, saida);
        end
        // pointer now 2: search 2,3 finds 3 before wrapping to 0
        in_valid = 4'b1001;
        tick();
        checks++;
        if (out_ch !== 2'd3 || saida !== 8'h13) begin
            errors++;
            $display("[TB] FAIL wrap_ch3: got ch=%0d data=%h expected ch=3 data=13", out_ch, saida);
        end
        tick();
        checks++;
        if (out_ch !== 2'd0 || saida !== 8'h10) begin
            errors++;
            $display("[TB] FAIL wrap_ch0: got ch=%0d data=%h expected ch=0 data=10", out_ch, saida);
        end
    endtask

    task automatic test_backpressure();
        // holding ch0 word, pointer = 1
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                mode = 1'b0;
                sel  = 2'd3;
            end
            tick();
            checks++;
            if (saida !== 8'h10 || out_ch !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got data=%h ch=%0d v=%b rdy=%b expected data=10 ch=0 v=1 rdy=0000",
                         k, saida, out_ch, out_valid, in_ready);
            end
        end
        mode      = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected %b", in_ready, 4'b0010);
        end
        tick();
        checks++;
        if (saida !== 8'h11 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_reload: got data=%h ch=%0d v=%b expected data=11 ch=1 v=1",
                     saida, out_ch, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        // output currently valid with ch1 word
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (saida !== 8'h00 || out_valid !== 1'b0 || out_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got data=%h v=%b ch=%0d expected data=00 v=0 ch=0",
                     saida, out_valid, out_ch);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_ch !== 2'd0 || saida !== 8'h10 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_rr_start: got ch=%0d data=%h v=%b expected ch=0 data=10 v=1",
                     out_ch, saida, out_valid);
        end
        in_valid = 4'b0000;
        tick();
    endtask

`ifdef MUX_CNT_EN
    task automatic test_counters();
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        // counters may hold one transfer from midstream test (ch0); clear first
        cnt_clr = 1'b1;
        in_valid = 4'b0000;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 4'b0001;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (grant_cnt !== 64'h0000_0000_0000_0003) begin
            errors++;
            $display("[TB] FAIL cnt_three: got %h expected %h", grant_cnt, 64'h3);
        end
        for (int k = 0; k < 69997; k++) tick();
        checks++;
        if (grant_cnt !== 64'h0000_0000_0000_FFFF) begin
            errors++;
            $display("[TB] FAIL cnt_saturate: got %h expected %h", grant_cnt, 64'hFFFF);
        end
        sel      = 2'd1;
        in_valid = 4'b0010;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 4'b0000;
        checks++;
        if (grant_cnt !== 64'h0) begin
            errors++;
            $display("[TB] FAIL cnt_clear: got %h expected %h", grant_cnt, 64'h0);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_manual();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_reset_midstream();
`ifdef MUX_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
